regfile_responder: RTL

REGFILE_RESPONDER -- requirements
Module: regfile_responder

---
 rtl/regfile_responder.sv | 87 ++++++++
 1 files changed

// File: rtl/regfile_responder.sv
// regfile_responder: 32 x 32-bit register file behind a valid/ready
// request/response pair. One outstanding response at most; a request may be
// accepted on the same edge that consumes the current response, so the block
// sustains one request per cycle while RspReady stays high.
//
// Ports:
//   Clk, Reset_n          clock, synchronous active-low reset
//   ReqValid/ReqReady     request handshake (ReqReady is combinational)
//   ReqWrite              1 = write, 0 = read
//   ReqAddr1, ReqAddr2    write target / read addresses (ReqAddr2 read only)
//   ReqWriteData          write payload
//   RspValid/RspReady     response handshake
//   RspData1, RspData2    read data, or committed value / 0 on writes
//   RspWriteAck           response belongs to a write
//   WriteCount            wrapping count of writes to nonzero registers
module regfile_responder (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [4:0]  ReqAddr1,
  input  logic [4:0]  ReqAddr2,
  input  logic [31:0] ReqWriteData,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspData1,
  output logic [31:0] RspData2,
  output logic        RspWriteAck,
  output logic [15:0] WriteCount
);

  localparam int unsigned NREG = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = 16;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t          state;
  logic [DW-1:0]   regs [NREG];
  logic            accept;
  logic            consume;
  logic            addr1_nz;

  // Response slot is free when empty or being drained this cycle.
  assign RspValid = (state == RESP);
  assign ReqReady = Reset_n & (~RspValid | RspReady);
  assign accept   = ReqValid & ReqReady;
  assign consume  = RspValid & RspReady;
  assign addr1_nz = (ReqAddr1 != AW'(0));

  // Storage, handshake state and registered response in one process.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      state       <= IDLE;
      RspData1    <= '0;
      RspData2    <= '0;
      RspWriteAck <= 1'b0;
      WriteCount  <= '0;
    end else if (accept) begin
      state <= RESP;
      if (ReqWrite) begin
        // Register 0 is hardwired to zero: no commit, no count.
        if (addr1_nz) begin
          regs[ReqAddr1] <= ReqWriteData;
          WriteCount     <= WriteCount + CW'(1);
        end
        RspData1    <= addr1_nz ? ReqWriteData : '0;
        RspData2    <= '0;
        RspWriteAck <= 1'b1;
      end else begin
        RspData1    <= regs[ReqAddr1];
        RspData2    <= regs[ReqAddr2];
        RspWriteAck <= 1'b0;
      end
    end else if (consume) begin
      // Drained with nothing behind it: outputs return to zero.
      state       <= IDLE;
      RspData1    <= '0;
      RspData2    <= '0;
      RspWriteAck <= 1'b0;
    end
  end

endmodule
